// File: rtl/phys_reg_free_list.sv
// Physical register free list: a circular buffer of free tags with speculative and
// committed read pointers, so that a flush restores the allocation state in one cycle.
module phys_reg_free_list #(
   parameter  int REG_FILE_ADDR_WIDTH = 7,
   parameter  int ARCH_REGS           = 32,
   localparam int DEPTH               = 2**REG_FILE_ADDR_WIDTH - ARCH_REGS,
   localparam int CW                  = $clog2(DEPTH + 1)
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           alloc_req,
   output logic                           alloc_valid,
   output logic [REG_FILE_ADDR_WIDTH-1:0] alloc_reg,
   input  logic                           commit_alloc,
   input  logic                           free_valid,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] free_reg,
   input  logic                           flush,
   output logic [CW-1:0]                  free_count,
   output logic                           error
);

   localparam int PW = $clog2(DEPTH);

   logic [REG_FILE_ADDR_WIDTH-1:0] buffer_q [DEPTH];
   logic [PW-1:0] spec_head_q, spec_head_d, commit_head_q, commit_head_d, tail_q, tail_d;
   logic [CW-1:0] spec_count_q, spec_count_d, commit_count_q, commit_count_d;
   logic          error_q, error_d;

   logic          alloc_valid_s, outstanding_s, free_nz_s;
   logic          free_ok_s, free_err_s, commit_ok_s, commit_err_s, alloc_ok_s, alloc_err_s;
   logic          buf_we_s;
   logic [PW-1:0] spec_head_adv_s;
   logic [CW-1:0] spec_count_adv_s;

   // DEPTH is not a power of two, so pointers wrap explicitly
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         ptr_inc = {PW{1'b0}};
      end else begin
         ptr_inc = p + PW'(1);
      end
   endfunction

   // Next-state: commit and free resolve first, a flush then rewinds the speculative side
   always_comb begin
      alloc_valid_s = (spec_count_q != {CW{1'b0}});
      outstanding_s = (commit_count_q > spec_count_q);
      free_nz_s     = free_valid && (free_reg != {REG_FILE_ADDR_WIDTH{1'b0}});
      free_ok_s     = free_nz_s && (commit_count_q < CW'(DEPTH));
      free_err_s    = free_nz_s && !free_ok_s;
      commit_ok_s   = commit_alloc && outstanding_s;
      commit_err_s  = commit_alloc && !outstanding_s;
      alloc_ok_s    = alloc_req && alloc_valid_s && !flush;
      alloc_err_s   = alloc_req && !alloc_valid_s && !flush;
      buf_we_s      = free_ok_s;

      if (free_ok_s) begin
         tail_d = ptr_inc(tail_q);
      end else begin
         tail_d = tail_q;
      end

      if (commit_ok_s) begin
         commit_head_d = ptr_inc(commit_head_q);
      end else begin
         commit_head_d = commit_head_q;
      end

      case ({free_ok_s, commit_ok_s})
         2'b10:   commit_count_d = commit_count_q + CW'(1);
         2'b01:   commit_count_d = commit_count_q - CW'(1);
         default: commit_count_d = commit_count_q;
      endcase

      case ({free_ok_s, alloc_ok_s})
         2'b10:   spec_count_adv_s = spec_count_q + CW'(1);
         2'b01:   spec_count_adv_s = spec_count_q - CW'(1);
         default: spec_count_adv_s = spec_count_q;
      endcase

      if (alloc_ok_s) begin
         spec_head_adv_s = ptr_inc(spec_head_q);
      end else begin
         spec_head_adv_s = spec_head_q;
      end

      if (flush) begin
         spec_head_d  = commit_head_d;
         spec_count_d = commit_count_d;
      end else begin
         spec_head_d  = spec_head_adv_s;
         spec_count_d = spec_count_adv_s;
      end

      error_d = error_q | free_err_s | commit_err_s | alloc_err_s;
   end

   // State registers; reset refills the buffer with every tag not identity-mapped
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            buffer_q[i] <= REG_FILE_ADDR_WIDTH'(ARCH_REGS + i);
         end
         spec_head_q    <= {PW{1'b0}};
         commit_head_q  <= {PW{1'b0}};
         tail_q         <= {PW{1'b0}};
         spec_count_q   <= CW'(DEPTH);
         commit_count_q <= CW'(DEPTH);
         error_q        <= 1'b0;
      end else begin
         if (buf_we_s) begin
            buffer_q[tail_q] <= free_reg;
         end
         spec_head_q    <= spec_head_d;
         commit_head_q  <= commit_head_d;
         tail_q         <= tail_d;
         spec_count_q   <= spec_count_d;
         commit_count_q <= commit_count_d;
         error_q        <= error_d;
      end
   end

   assign alloc_valid = alloc_valid_s;
   assign alloc_reg   = buffer_q[spec_head_q];
   assign free_count  = spec_count_q;
   assign error       = error_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: a vector table plus directed sequences, with expected
// outputs queued as each cycle is driven and compared after the clock edge.
module tb_phys_reg_free_list;

   localparam int W  = 7;
   localparam int CW = 7;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          alloc_req = 1'b0, commit_alloc = 1'b0, free_valid = 1'b0, flush = 1'b0;
   logic [W-1:0]  free_reg = '0;
   logic          alloc_valid, error;
   logic [W-1:0]  alloc_reg;
   logic [CW-1:0] free_count;

   typedef struct {
      logic          rst_n;
      logic          ar;
      logic          ca;
      logic          fv;
      logic [W-1:0]  fr;
      logic          fl;
      logic          ev;
      logic [W-1:0]  er;
      logic [CW-1:0] ec;
      logic          ee;
      string         name;
   } vec_t;

   vec_t exp_q[$];
   vec_t tbl[13];
   int   n_cmp = 0;
   int   n_bad = 0;

   phys_reg_free_list dut (
      .clock(clock), .reset_n(reset_n), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
      .alloc_reg(alloc_reg), .commit_alloc(commit_alloc), .free_valid(free_valid),
      .free_reg(free_reg), .flush(flush), .free_count(free_count), .error(error)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic rst_n, input logic ar, input logic ca,
                               input logic fv, input logic [W-1:0] fr, input logic fl,
                               input logic ev, input logic [W-1:0] er,
                               input logic [CW-1:0] ec, input logic ee, input string name);
      vec_t v;
      v.rst_n = rst_n; v.ar = ar; v.ca = ca; v.fv = fv; v.fr = fr; v.fl = fl;
      v.ev = ev; v.er = er; v.ec = ec; v.ee = ee; v.name = name;
      return v;
   endfunction

   task automatic check_out();
      vec_t e;
      e = exp_q.pop_front();
      n_cmp += 4;
      if (alloc_valid !== e.ev) begin
         n_bad++;
         $display("FAIL %s alloc_valid: got %0b want %0b", e.name, alloc_valid, e.ev);
      end
      if (alloc_reg !== e.er) begin
         n_bad++;
         $display("FAIL %s alloc_reg: got %0d want %0d", e.name, alloc_reg, e.er);
      end
      if (free_count !== e.ec) begin
         n_bad++;
         $display("FAIL %s free_count: got %0d want %0d", e.name, free_count, e.ec);
      end
      if (error !== e.ee) begin
         n_bad++;
         $display("FAIL %s error: got %0b want %0b", e.name, error, e.ee);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge clock);
      reset_n = v.rst_n; alloc_req = v.ar; commit_alloc = v.ca;
      free_valid = v.fv; free_reg = v.fr; flush = v.fl;
      exp_q.push_back(v);
      @(posedge clock);
      #1;
      check_out();
   endtask

   task automatic drv(input logic rst_n, input logic ar, input logic ca, input logic fv,
                      input logic [W-1:0] fr, input logic fl, input logic ev,
                      input logic [W-1:0] er, input logic [CW-1:0] ec, input logic ee,
                      input string name);
      apply(mk(rst_n, ar, ca, fv, fr, fl, ev, er, ec, ee, name));
   endtask

   initial begin
      //               rst ar ca fv fr  fl   ev  er  cnt err
      tbl[0]  = mk(1'b1, 0, 0, 0, 7'd0,  0, 1, 7'd32, 7'd96, 0, "idle");
      tbl[1]  = mk(1'b1, 0, 0, 1, 7'd0,  0, 1, 7'd32, 7'd96, 0, "free_p0");
      tbl[2]  = mk(1'b1, 1, 0, 0, 7'd0,  0, 1, 7'd33, 7'd95, 0, "alloc1");
      tbl[3]  = mk(1'b1, 1, 0, 0, 7'd0,  0, 1, 7'd34, 7'd94, 0, "alloc2");
      tbl[4]  = mk(1'b1, 0, 1, 0, 7'd0,  0, 1, 7'd34, 7'd94, 0, "commit1");
      tbl[5]  = mk(1'b1, 0, 0, 0, 7'd0,  1, 1, 7'd33, 7'd95, 0, "flush_rewind");
      tbl[6]  = mk(1'b1, 1, 0, 1, 7'd5,  0, 1, 7'd34, 7'd95, 0, "alloc_and_free");
      tbl[7]  = mk(1'b1, 0, 1, 0, 7'd0,  0, 1, 7'd34, 7'd95, 0, "commit2");
      tbl[8]  = mk(1'b1, 0, 1, 0, 7'd0,  0, 1, 7'd34, 7'd95, 1, "commit_none");
      tbl[9]  = mk(1'b0, 0, 0, 0, 7'd0,  0, 1, 7'd32, 7'd96, 0, "reset_clears");
      tbl[10] = mk(1'b1, 0, 0, 1, 7'd40, 0, 1, 7'd32, 7'd96, 1, "free_when_full");
      tbl[11] = mk(1'b0, 0, 0, 0, 7'd0,  0, 1, 7'd32, 7'd96, 0, "reset_again");
      tbl[12] = mk(1'b1, 1, 0, 0, 7'd0,  1, 1, 7'd32, 7'd96, 0, "flush_blocks_alloc");

      drv(1'b0, 0, 0, 0, 7'd0, 0, 1, 7'd32, 7'd96, 0, "reset");
      drv(1'b0, 0, 0, 0, 7'd0, 0, 1, 7'd32, 7'd96, 0, "reset_hold");

      for (int i = 0; i < 13; i++) apply(tbl[i]);

      // allocate five, commit two, flush: speculative head returns to third tag
      for (int i = 0; i < 5; i++)
         drv(1'b1, 1, 0, 0, 7'd0, 0, 1, W'(33 + i), CW'(95 - i), 0, "alloc5");
      drv(1'b1, 0, 1, 0, 7'd0, 0, 1, 7'd37, 7'd91, 0, "c2_commit_a");
      drv(1'b1, 0, 1, 0, 7'd0, 0, 1, 7'd37, 7'd91, 0, "c2_commit_b");
      drv(1'b1, 0, 0, 0, 7'd0, 1, 1, 7'd34, 7'd94, 0, "c2_flush");

      // drain all 96 tags, head wraps back to slot 0
      drv(1'b0, 0, 0, 0, 7'd0, 0, 1, 7'd32, 7'd96, 0, "drain_reset");
      for (int i = 0; i < 96; i++)
         drv(1'b1, 1, 0, 0, 7'd0, 0, (i < 95), (i < 95) ? W'(33 + i) : 7'd32,
             CW'(95 - i), 0, "drain");
      for (int i = 0; i < 96; i++)
         drv(1'b1, 0, 1, 0, 7'd0, 0, 0, 7'd32, 7'd0, 0, "commit_all");
      drv(1'b1, 1, 0, 1, 7'd7, 0, 1, 7'd7, 7'd1, 1, "free7_alloc_empty");
      drv(1'b1, 1, 0, 0, 7'd0, 0, 0, 7'd33, 7'd0, 1, "alloc_freed7");
      drv(1'b1, 1, 0, 0, 7'd0, 0, 0, 7'd33, 7'd0, 1, "alloc_empty_again");

      // mid-operation reset with a concurrent alloc request
      drv(1'b0, 0, 0, 0, 7'd0, 0, 1, 7'd32, 7'd96, 0, "mid_reset0");
      for (int i = 0; i < 3; i++)
         drv(1'b1, 1, 0, 0, 7'd0, 0, 1, W'(33 + i), CW'(95 - i), 0, "alloc3");
      drv(1'b0, 1, 0, 0, 7'd0, 0, 1, 7'd32, 7'd96, 0, "reset_with_alloc");
      drv(1'b1, 0, 0, 0, 7'd0, 0, 1, 7'd32, 7'd96, 0, "post_reset_idle");

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
